bank_interleave_sequencer: RTL and testbench

- Synthesizable DDR4 command sequencer that replaces hand-timed bank-interleaving stimulus.
- It activates every bank of one rank in a selectable interleave order and spaces each command by programmable timing gaps. It can then issue RD or WR to each open bank and precharge them all.
- It drives the DDR4 command pins of the dimm model directly and sits between a test controller (start/abort) and the dimm.

---
 rtl/bank_interleave_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_bank_interleave_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_interleave_sequencer.sv
// DDR4 bank-interleave command sequencer: opens every bank of one rank in a chosen order,
// optionally issues RD/WR to each open bank, precharges them, and reports completion.
module bank_interleave_sequencer #(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRRD_S    = 2,
    parameter int TRRD_L    = 4,
    parameter int TRCD      = 8,
    parameter int TCCD      = 4,
    parameter int TCAS2PRE  = 6,
    parameter int TRP       = 8,
    localparam int RW       = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [1:0]           op,
    input  logic [RW-1:0]        rank,
    input  logic [ADDRWIDTH-1:0] row,
    input  logic [COLWIDTH-1:0]  col,
    input  logic [BGWIDTH-1:0]   sel_bg,
    input  logic [BAWIDTH-1:0]   sel_ba,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 rd_strobe,
    output logic                 wr_strobe,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);
    localparam int KW   = BGWIDTH + BAWIDTH;
    localparam int MX1  = (TRRD_S > TRRD_L) ? TRRD_S : TRRD_L;
    localparam int MX2  = (TRCD > TCCD) ? TRCD : TCCD;
    localparam int MX3  = (TCAS2PRE > TRP) ? TCAS2PRE : TRP;
    localparam int MX12 = (MX1 > MX2) ? MX1 : MX2;
    localparam int MAXT = (MX12 > MX3) ? MX12 : MX3;
    // +1 headroom: the abort path waits TRP+1 cycles after PREA
    localparam int GW   = $clog2(MAXT + 2);

    typedef enum logic [2:0] {S_IDLE, S_ACT, S_CAS, S_PRE, S_PREA, S_WAIT_TRP, S_DONE} state_t;
    typedef enum logic [2:0] {C_NONE, C_ACT, C_CAS, C_PRE, C_PREA} cmd_t;

    state_t               state_reg, state_next;
    cmd_t                 cmd;
    logic [KW-1:0]        k_reg, k_next, last_k, map_cur, map_nxt;
    logic [GW-1:0]        gap_reg, gap_next;
    logic [RW-1:0]        rank_reg, rank_next;
    logic [ADDRWIDTH-1:0] row_reg, row_next, a_reg, a_next;
    logic [COLWIDTH-1:0]  col_reg, col_next;
    logic [1:0]           mode_reg, mode_next, op_reg, op_next;
    logic [BGWIDTH-1:0]   sbg_reg, sbg_next, bg_reg, bg_next;
    logic [BAWIDTH-1:0]   sba_reg, sba_next, ba_reg, ba_next;
    logic [RANKS-1:0]     cs_n_reg, cs_n_next;
    logic                 abrt_reg, abrt_next;
    logic                 act_n_reg, act_n_next, rd_reg, rd_next, wr_reg, wr_next;
    logic                 busy_reg, busy_next, done_reg, done_next, aborted_reg, aborted_next;

    // Packed {bg, ba} for bank index k under the given interleave mode
    function automatic logic [KW-1:0] map_bank(input logic [KW-1:0] k, input logic [1:0] m,
                                               input logic [BGWIDTH-1:0] sbg,
                                               input logic [BAWIDTH-1:0] sba);
        case (m)
            2'd1:    map_bank = {k[BGWIDTH-1:0], k[KW-1:BGWIDTH]};
            2'd2:    map_bank = {sbg, sba};
            default: map_bank = k;
        endcase
    endfunction

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        gap_next     = gap_reg;
        abrt_next    = abrt_reg;
        rank_next    = rank_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        mode_next    = mode_reg;
        op_next      = op_reg;
        sbg_next     = sbg_reg;
        sba_next     = sba_reg;
        cmd          = C_NONE;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        busy_next    = busy_reg;

        if (state_reg == S_IDLE && start) begin
            rank_next = rank;
            row_next  = row;
            col_next  = col;
            mode_next = (mode == 2'd3) ? 2'd0 : mode;
            op_next   = (op == 2'd3) ? 2'd0 : op;
            sbg_next  = sel_bg;
            sba_next  = sel_ba;
            abrt_next = 1'b0;
        end
        last_k = (mode_next == 2'd2) ? '0 : '1;

        case (state_reg)
            S_IDLE: begin
                // The first ACT leaves on the same edge, so a later abort always follows an ACT
                if (start) begin
                    cmd        = C_ACT;
                    k_next     = '0;
                    state_next = S_ACT;
                    busy_next  = 1'b1;
                end
            end
            S_ACT, S_CAS, S_PRE: begin
                if (abort) begin
                    cmd        = C_PREA;
                    state_next = S_PREA;
                end else if (gap_reg == GW'(1)) begin
                    if (state_reg == S_ACT && k_reg == last_k) begin
                        if (op_reg == 2'd0) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                        end else begin
                            cmd        = C_CAS;
                            k_next     = '0;
                            state_next = S_CAS;
                        end
                    end else if (state_reg == S_CAS && k_reg == last_k) begin
                        cmd        = C_PRE;
                        k_next     = '0;
                        state_next = S_PRE;
                    end else begin
                        cmd    = (state_reg == S_ACT) ? C_ACT : (state_reg == S_CAS) ? C_CAS : C_PRE;
                        k_next = k_reg + KW'(1);
                    end
                end else begin
                    gap_next = gap_reg - GW'(1);
                end
            end
            S_PREA, S_WAIT_TRP: begin
                state_next = S_WAIT_TRP;
                if (gap_reg == GW'(1)) begin
                    state_next   = S_DONE;
                    done_next    = 1'b1;
                    aborted_next = abrt_reg;
                    busy_next    = 1'b0;
                end else begin
                    gap_next = gap_reg - GW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        map_cur = map_bank(k_next, mode_next, sbg_next, sba_next);
        map_nxt = map_bank(k_next + KW'(1), mode_next, sbg_next, sba_next);

        case (cmd)
            C_ACT: begin
                if (k_next == last_k)
                    gap_next = (op_next == 2'd0) ? GW'(1) : GW'(TRCD);
                else if (map_cur[KW-1:BAWIDTH] == map_nxt[KW-1:BAWIDTH])
                    gap_next = GW'(TRRD_L);
                else
                    gap_next = GW'(TRRD_S);
            end
            C_CAS: gap_next = (k_next == last_k) ? GW'(TCAS2PRE) : GW'(TCCD);
            C_PRE: begin
                if (k_next == last_k) begin
                    gap_next   = GW'(TRP);
                    state_next = S_WAIT_TRP;
                end else begin
                    gap_next = GW'(1);
                end
            end
            C_PREA: begin
                gap_next  = GW'(TRP + 1);
                abrt_next = 1'b1;
            end
            default: ;
        endcase

        cs_n_next  = '1;
        act_n_next = 1'b1;
        a_next     = '0;
        bg_next    = bg_reg;
        ba_next    = ba_reg;
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        if (cmd != C_NONE) begin
            for (int i = 0; i < RANKS; i++)
                cs_n_next[i] = (rank_next != RW'(i));
        end
        if (cmd == C_ACT || cmd == C_CAS || cmd == C_PRE)
            {bg_next, ba_next} = map_cur;
        case (cmd)
            C_ACT: begin
                act_n_next = 1'b0;
                a_next     = row_next;
            end
            C_CAS: begin
                a_next[COLWIDTH-1:0] = col_next;
                a_next[10]           = 1'b0;
                a_next[16]           = 1'b1;
                a_next[14]           = (op_next == 2'd1);
                rd_next              = (op_next == 2'd1);
                wr_next              = (op_next == 2'd2);
            end
            C_PRE:  a_next[15] = 1'b1;
            C_PREA: begin
                a_next[15] = 1'b1;
                a_next[10] = 1'b1;
            end
            default: ;
        endcase
        if (state_next == S_DONE) begin
            bg_next = '0;
            ba_next = '0;
        end
    end

    always_ff @(posedge ck_t or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            k_reg       <= '0;
            gap_reg     <= '0;
            abrt_reg    <= 1'b0;
            rank_reg    <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            mode_reg    <= '0;
            op_reg      <= '0;
            sbg_reg     <= '0;
            sba_reg     <= '0;
            cs_n_reg    <= '1;
            act_n_reg   <= 1'b1;
            a_reg       <= '0;
            bg_reg      <= '0;
            ba_reg      <= '0;
            rd_reg      <= 1'b0;
            wr_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            gap_reg     <= gap_next;
            abrt_reg    <= abrt_next;
            rank_reg    <= rank_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            mode_reg    <= mode_next;
            op_reg      <= op_next;
            sbg_reg     <= sbg_next;
            sba_reg     <= sba_next;
            cs_n_reg    <= cs_n_next;
            act_n_reg   <= act_n_next;
            a_reg       <= a_next;
            bg_reg      <= bg_next;
            ba_reg      <= ba_next;
            rd_reg      <= rd_next;
            wr_reg      <= wr_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    assign cs_n      = cs_n_reg;
    assign act_n     = act_n_reg;
    assign A         = a_reg;
    assign bg        = bg_reg;
    assign ba        = ba_reg;
    assign rd_strobe = rd_reg;
    assign wr_strobe = wr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;
endmodule

// File: tb/tb_bank_interleave_sequencer.sv
// Scoreboard bench: a timeline model of each sequence is queued at start and a negedge monitor
// compares every command / done cycle the DUT produces against it.
module tb_bank_interleave_sequencer;
    localparam int RANKS = 2, BGW = 2, BAW = 2, AW = 17, CW = 10;
    localparam int TRRD_S = 2, TRRD_L = 4, TRCD = 8, TCCD = 4, TCAS2PRE = 6, TRP = 8;
    localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_PREA = 4, K_DONE = 5;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [1:0] mode = '0, op = '0;
    logic [0:0] rank = '0;
    logic [AW-1:0] row = '0;
    logic [CW-1:0] col = '0;
    logic [BGW-1:0] sel_bg = '0;
    logic [BAW-1:0] sel_ba = '0;
    logic [RANKS-1:0] cs_n;
    logic act_n, rd_strobe, wr_strobe, busy, done, aborted;
    logic [AW-1:0] A;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;

    typedef struct {int t; int kind; int bg; int ba; int a; int csn; int ab;} ev_t;
    ev_t sbq[$];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bank_interleave_sequencer #(
        .RANKS(RANKS), .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
        .TRRD_S(TRRD_S), .TRRD_L(TRRD_L), .TRCD(TRCD), .TCCD(TCCD), .TCAS2PRE(TCAS2PRE), .TRP(TRP)
    ) dut (
        .ck_t(clk), .reset(reset), .start(start), .abort(abort), .mode(mode), .op(op),
        .rank(rank), .row(row), .col(col), .sel_bg(sel_bg), .sel_ba(sel_ba),
        .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba), .rd_strobe(rd_strobe),
        .wr_strobe(wr_strobe), .busy(busy), .done(done), .aborted(aborted)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cs_n"}, cs_n, 3);
        chk({tag, "_act_n"}, act_n, 1);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_bgba"}, {bg, ba}, 0);
        chk({tag, "_strobes"}, {rd_strobe, wr_strobe}, 0);
        chk({tag, "_busy_done_ab"}, {busy, done, aborted}, 0);
    endtask

    function automatic int decode();
        if (done) return K_DONE;
        if (!act_n) return K_ACT;
        case (A[16:14])
            3'b101:  return K_RD;
            3'b100:  return K_WR;
            3'b010:  return A[10] ? K_PREA : K_PRE;
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (cs_n != 2'b11 || done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_event", decode(), -1);
                end else begin
                    e = sbq.pop_front();
                    chk("event_time", cyc, e.t);
                    chk("event_kind", decode(), e.kind);
                    if (e.kind == K_DONE) begin
                        chk("done_aborted", aborted, e.ab);
                        chk("done_busy", busy, 0);
                    end else begin
                        chk("cmd_cs_n", cs_n, e.csn);
                        chk("cmd_A", A, e.a);
                        if (e.kind != K_PREA) chk("cmd_bgba", bg * 4 + ba, e.bg * 4 + e.ba);
                        chk("cmd_rd_strobe", rd_strobe, (e.kind == K_RD) ? 1 : 0);
                        chk("cmd_wr_strobe", wr_strobe, (e.kind == K_WR) ? 1 : 0);
                        chk("cmd_busy", busy, 1);
                    end
                end
            end else begin
                chk("desel_act_n_A", {act_n, A}, 1 << AW);
                chk("desel_strobes", {rd_strobe, wr_strobe, aborted}, 0);
            end
        end
    end

    // Model: absolute command timeline from the timing rules; abort truncates it at cycle x
    task automatic run_seq(input int m, input int o, input int r_row, input int r_col, input int rk,
                           input int sbg, input int sba, input int abort_act, input bit rand_abort,
                           input bit reset_mid);
        ev_t evs[$];
        int mm, oo, n, t, csn, last_act, last_pre, x, base, upper;
        int bgk[16], bak[16], act_t[16];
        mm = (m == 3) ? 0 : m;
        oo = (o == 3) ? 0 : o;
        n = (mm == 2) ? 1 : 16;
        csn = (rk == 0) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            bgk[k] = (mm == 0) ? k / 4 : (mm == 1) ? k % 4 : sbg;
            bak[k] = (mm == 0) ? k % 4 : (mm == 1) ? k / 4 : sba;
        end
        t = 0;
        for (int k = 0; k < n; k++) begin
            act_t[k] = t;
            evs.push_back('{t, K_ACT, bgk[k], bak[k], r_row, csn, 0});
            if (k < n - 1) t += (bgk[k] == bgk[k + 1]) ? TRRD_L : TRRD_S;
        end
        last_act = t;
        last_pre = 0;
        if (oo == 0) begin
            evs.push_back('{last_act + 1, K_DONE, 0, 0, 0, 3, 0});
        end else begin
            t = last_act + TRCD;
            for (int k = 0; k < n; k++) begin
                evs.push_back('{t, (oo == 1) ? K_RD : K_WR, bgk[k], bak[k],
                                (oo == 1) ? (65536 + 16384 + r_col) : (65536 + r_col), csn, 0});
                if (k < n - 1) t += TCCD;
            end
            t += TCAS2PRE;
            for (int k = 0; k < n; k++) begin
                evs.push_back('{t, K_PRE, bgk[k], bak[k], 32768, csn, 0});
                last_pre = t;
                t++;
            end
            evs.push_back('{last_pre + TRP, K_DONE, 0, 0, 0, 3, 0});
        end
        x = -1;
        if (abort_act > 0) x = act_t[abort_act - 1];
        else if (rand_abort) begin
            upper = (oo == 0) ? last_act : last_pre - 1;
            x = $urandom_range(0, upper);
        end
        if (x >= 0) begin
            while (evs.size() > 0 && evs[evs.size() - 1].t > x) void'(evs.pop_back());
            evs.push_back('{x + 1, K_PREA, 0, 0, 32768 + 1024, csn, 0});
            evs.push_back('{x + 2 + TRP, K_DONE, 0, 0, 0, 3, 1});
        end

        @(posedge clk); #1;
        mode = m[1:0]; op = o[1:0]; rank = rk[0:0]; row = r_row[AW-1:0]; col = r_col[CW-1:0];
        sel_bg = sbg[1:0]; sel_ba = sba[1:0];
        start = 1'b1;
        base = cyc + 1;
        foreach (evs[i]) begin
            ev_t e;
            e = evs[i];
            e.t = e.t + base;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        // start stays high one extra cycle while busy and must be ignored
        do begin
            abort = (x >= 0 && cyc == base + x);
            start = (cyc == base);
            @(posedge clk); #1;
        end while (cyc <= base + ((x > 1) ? x : 1));
        abort = 1'b0;
        start = 1'b0;

        if (reset_mid) begin
            while (cyc < base + last_act + TRCD + 5) begin @(posedge clk); #1; end
            reset = 1'b1;
            sbq.delete();
            #1;
            check_reset("midrst");
            repeat (2) begin @(posedge clk); #1; end
            check_reset("midrst_hold");
            reset = 1'b0;
        end else begin
            upper = 0;
            while (sbq.size() != 0 && upper < 3000) begin @(posedge clk); upper++; end
            chk("timeout_pending", sbq.size(), 0);
            sbq.delete();
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_cs_n", cs_n, 3);
        end
        $display("seq mode=%0d op=%0d rank=%0d row=%0h col=%0h abort_at=%0d reset_mid=%0d events=%0d",
                 m, o, rk, r_row, r_col, x, reset_mid, evs.size());
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        run_seq(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_seq(1, 0, $urandom_range(0, 131071), 0, 0, 0, 0, 0, 0, 0);
        run_seq(2, 1, $urandom_range(0, 131071), 'h15, 0, 2, 3, 0, 0, 0);
        run_seq(0, 2, $urandom_range(0, 131071), $urandom_range(0, 1023), 0, 0, 0, 0, 0, 0);
        run_seq(0, 1, $urandom_range(0, 131071), $urandom_range(0, 1023), 0, 0, 0, 5, 0, 0);
        run_seq(0, 1, $urandom_range(0, 131071), $urandom_range(0, 1023), 1, 0, 0, 0, 0, 1);
        run_seq(2, 2, $urandom_range(0, 131071), $urandom_range(0, 1023), 1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 131071),
                    $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 3), 0, ($urandom_range(0, 2) == 0), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
